// File: rtl/spi_serf_regs.sv
// SPI responder for 16-bit {R/W_n, addr[6:0], data[7:0]} frames from the SPI monarch.
// Holds a 15-entry 8-bit register file (0x0-0xE), a read-only WHO_AM_I at 0x0F, and a
// local update port. All SPI pins are asynchronous to clk and are synchronized here.
module spi_serf_regs #(
  parameter logic [7:0] WHO_AM_I    = 8'h6A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       upd,
  input  logic [3:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       xfer_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_SS} state_t;

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;        // last seven received bits; the eighth is MOSI_s itself
  logic [7:0] tx_q, tx_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] data_q, data_d;
  logic [7:0] regs_q [15];
  logic [7:0] regs_d [15];
  logic       wr_q, wr_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       xfer_done_q, xfer_done_d;

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise;
  logic [7:0] cmd_new;

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign cmd_new   = {rx_q, mosi_s};

  assign MISO      = ((state_q == DATA) || (state_q == WAIT_SS)) ? tx_q[7] : 1'b0;
  assign wr        = wr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign xfer_done = xfer_done_q;

  // Read mux: WHO_AM_I at 0x0F, register file below it, zero above
  function automatic logic [7:0] rdval(input logic [6:0] addr);
    if (addr == 7'h0F)     return WHO_AM_I;
    else if (addr < 7'h0F) return regs_q[addr[3:0]];
    else                   return 8'h00;
  endfunction

  // Synchronizer shift chains plus one edge-detect flop for SS_n and SCLK
  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ss_prev_d   = ss_s;
    sclk_prev_d = sclk_s;
  end

  // Frame state machine, shift registers, register file and commit strobes
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    regs_d      = regs_q;
    wr_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    xfer_done_d = 1'b0;

    // Local update first so a same-cycle SPI commit below overrides it
    if (upd && (upd_addr != 4'hF)) begin
      regs_d[upd_addr] = upd_data;
    end

    // SS_n edges win over any SCLK edge seen in the same cycle
    if (ss_rise) begin
      xfer_done_d = 1'b1;
      if ((state_q == WAIT_SS) && !cmd_q[7] && (cmd_q[6:0] < 7'h0F)) begin
        regs_d[cmd_q[3:0]] = data_q;
        wr_d      = 1'b1;
        wr_addr_d = cmd_q[3:0];
        wr_data_d = data_q;
      end
      state_d = IDLE;
    end else if (ss_fall) begin
      if (state_q == IDLE) begin
        bit_cnt_d = 4'd0;
        rx_d      = 7'd0;
        tx_d      = 8'd0;
        state_d   = CMD;
      end
    end else if (sclk_rise && ((state_q == CMD) || (state_q == DATA))) begin
      rx_d      = {rx_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (state_q == DATA) begin
        tx_d = {tx_q[6:0], 1'b0};
        if (bit_cnt_q == 4'd15) begin
          data_d  = cmd_new;
          state_d = WAIT_SS;
        end
      end else if (bit_cnt_q == 4'd7) begin
        cmd_d   = cmd_new;
        tx_d    = cmd_new[7] ? rdval(cmd_new[6:0]) : 8'h00;
        state_d = DATA;
      end
    end
  end

  // Register every piece of state; reset returns the block to idle with cleared registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      cmd_q       <= 8'd0;
      data_q      <= 8'd0;
      for (int i = 0; i < 15; i++) regs_q[i] <= 8'h00;
      wr_q        <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'd0;
      xfer_done_q <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_prev_q   <= ss_prev_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      regs_q      <= regs_d;
      wr_q        <= wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      xfer_done_q <= xfer_done_d;
    end
  end

endmodule
